// File: rtl/vga_pixel_capture.sv
// vga_pixel_capture: packs the host's serial video into VRAM bytes and queues {addr,data} for the arbiter.
// Build option CAPTURE_INVERT_EN stores inverted pixels (host drives 1=black, VRAM stores 1=white).
module vga_pixel_capture #(
  parameter int unsigned H_ACTIVE   = 512,
  parameter int unsigned V_ACTIVE   = 342,
  parameter int unsigned H_SKIP     = 0,
  parameter int unsigned V_SKIP     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        pixEn,
  input  logic        vidIn,
  input  logic        hsyncIn,
  input  logic        vsyncIn,
  output logic        wrReq,
  output logic [14:0] wrAddr,
  output logic [7:0]  wrData,
  input  logic        wrAck,
  output logic        capActive,
  output logic        ovf
);
  localparam int unsigned BYTES_PER_LINE = H_ACTIVE / 8;
  localparam int unsigned PIX_W    = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned SKIP_MAX = (H_SKIP > V_SKIP) ? H_SKIP : V_SKIP;
  localparam int unsigned SKIP_W   = $clog2(SKIP_MAX + 2);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, VSKIP, HWAIT, HSKIP, ACTIVE} state_t;
  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_ent_t;

  localparam state_t FRAME_START = (V_SKIP == 0) ? HWAIT : VSKIP;
  localparam state_t LINE_START  = (H_SKIP == 0) ? ACTIVE : HSKIP;

  state_t              state, state_nxt;
  logic                hs_q, vs_q, hs_fall, vs_fall, pix_bit;
  logic [PIX_W-1:0]    pix_cnt, pix_cnt_nxt;
  logic [LINE_W-1:0]   line_cnt, line_cnt_nxt;
  logic [SKIP_W-1:0]   skip_cnt, skip_cnt_nxt;
  logic [7:0]          shift_q, shift_nxt;
  logic                push_c, ovf_clr_c;
  wr_ent_t             push_ent_c;

  wr_ent_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic                pop_c, full_c, push_ok_c, head_from_push_c;

`ifdef CAPTURE_INVERT_EN
  assign pix_bit = ~vidIn;
`else
  assign pix_bit = vidIn;
`endif

  // Falling edge seen in the clk where the input first reads 0.
  assign hs_fall = hs_q & ~hsyncIn;
  assign vs_fall = vs_q & ~vsyncIn;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      skip_cnt  <= '0;
      shift_q   <= '0;
      capActive <= 1'b0;
    end else begin
      state     <= state_nxt;
      hs_q      <= hsyncIn;
      vs_q      <= vsyncIn;
      pix_cnt   <= pix_cnt_nxt;
      line_cnt  <= line_cnt_nxt;
      skip_cnt  <= skip_cnt_nxt;
      shift_q   <= shift_nxt;
      capActive <= (state_nxt == ACTIVE);
    end
  end

  // Sync edges take priority over a coincident pixel strobe.
  always_comb begin
    state_nxt    = state;
    pix_cnt_nxt  = pix_cnt;
    line_cnt_nxt = line_cnt;
    skip_cnt_nxt = skip_cnt;
    shift_nxt    = shift_q;
    push_c       = 1'b0;
    push_ent_c   = '0;
    ovf_clr_c    = 1'b0;
    if (vs_fall) begin
      ovf_clr_c    = 1'b1;
      line_cnt_nxt = '0;
      pix_cnt_nxt  = '0;
      skip_cnt_nxt = '0;
      shift_nxt    = '0;
      state_nxt    = FRAME_START;
    end else begin
      unique case (state)
        IDLE: ;
        VSKIP: if (hs_fall) begin
          skip_cnt_nxt = skip_cnt + SKIP_W'(1);
          if (skip_cnt_nxt == SKIP_W'(V_SKIP)) begin
            skip_cnt_nxt = '0;
            state_nxt    = HWAIT;
          end
        end
        HWAIT: if (hs_fall) begin
          pix_cnt_nxt  = '0;
          skip_cnt_nxt = '0;
          shift_nxt    = '0;
          state_nxt    = LINE_START;
        end
        HSKIP: if (hs_fall) begin
          skip_cnt_nxt = '0;
        end else if (pixEn) begin
          skip_cnt_nxt = skip_cnt + SKIP_W'(1);
          if (skip_cnt_nxt == SKIP_W'(H_SKIP)) begin
            skip_cnt_nxt = '0;
            state_nxt    = ACTIVE;
          end
        end
        ACTIVE: if (hs_fall) begin
          line_cnt_nxt = line_cnt + LINE_W'(1);
          pix_cnt_nxt  = '0;
          shift_nxt    = '0;
          state_nxt    = (line_cnt_nxt == LINE_W'(V_ACTIVE)) ? IDLE : LINE_START;
        end else if (pixEn) begin
          shift_nxt   = {shift_q[6:0], pix_bit};
          pix_cnt_nxt = pix_cnt + PIX_W'(1);
          if (pix_cnt[2:0] == 3'd7) begin
            push_c          = 1'b1;
            push_ent_c.addr = 15'(32'(line_cnt) * BYTES_PER_LINE + 32'(pix_cnt >> 3));
            push_ent_c.data = shift_nxt;
          end
          if (pix_cnt_nxt == PIX_W'(H_ACTIVE)) begin
            line_cnt_nxt = line_cnt + LINE_W'(1);
            pix_cnt_nxt  = '0;
            state_nxt    = (line_cnt_nxt == LINE_W'(V_ACTIVE)) ? IDLE : HWAIT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same clk.
  always_comb begin
    pop_c            = wrReq & wrAck;
    full_c           = (count == CNT_W'(FIFO_DEPTH));
    push_ok_c        = push_c & (~full_c | pop_c);
    head_from_push_c = push_ok_c & ((count == '0) | (pop_c & (count == CNT_W'(1))));
    count_nxt        = count;
    if (push_ok_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (!push_ok_c && pop_c) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_ent_c;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      wrReq  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      wrReq <= (count_nxt != '0);
      if (head_from_push_c) begin
        wrAddr <= push_ent_c.addr;
        wrData <= push_ent_c.data;
      end else if (pop_c && count_nxt != '0) begin
        wrAddr <= mem[rd_ptr + PTR_W'(1)].addr;
        wrData <= mem[rd_ptr + PTR_W'(1)].data;
      end
      if (ovf_clr_c)                      ovf <= 1'b0;
      else if (push_c && full_c && !pop_c) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_capture.sv
// Randomized bench for vga_pixel_capture: frame-level pixel generator plus a queue model of the write FIFO.
module tb_vga_pixel_capture;
  localparam int unsigned H_ACTIVE   = 512;
  localparam int unsigned V_ACTIVE   = 4;
  localparam int unsigned H_SKIP     = 2;
  localparam int unsigned V_SKIP     = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BPL        = H_ACTIVE / 8;
`ifdef CAPTURE_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
  } ent_t;

  logic        clk = 1'b0;
  logic        nReset, pixEn, vidIn, hsyncIn, vsyncIn, wrAck;
  logic        wrReq, capActive, ovf;
  logic [14:0] wrAddr;
  logic [7:0]  wrData;

  ent_t        mq[$];
  ent_t        drv_ent;
  bit          m_ovf, drv_push, drv_vclr, chk_en, armed, full, popped;
  int          vectors, errors, ack_mode, line_no, n_writes, base;
  logic [14:0] last_addr;
  logic [14:0] seen_addr[$];
  logic [7:0]  exp_b;

  vga_pixel_capture #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_SKIP(H_SKIP),
    .V_SKIP(V_SKIP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .nReset(nReset), .pixEn(pixEn), .vidIn(vidIn),
    .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .wrReq(wrReq), .wrAddr(wrAddr),
    .wrData(wrData), .wrAck(wrAck), .capActive(capActive), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue model of the FIFO plus observed write log.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (wrReq && wrAck) begin
        n_writes++;
        last_addr = wrAddr;
        seen_addr.push_back(wrAddr);
      end
      full   = (mq.size() == FIFO_DEPTH);
      popped = 1'b0;
      if (wrAck && mq.size() != 0) begin
        void'(mq.pop_front());
        popped = 1'b1;
      end
      if (drv_push) begin
        if (!full || popped) mq.push_back(drv_ent);
        else m_ovf = 1'b1;
      end
      if (drv_vclr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && nReset) begin
      check("wrReq", 32'(wrReq), 32'(mq.size() != 0));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (mq.size() != 0) begin
        check("wrAddr", 32'(wrAddr), 32'(mq[0].addr));
        check("wrData", 32'(wrData), 32'(mq[0].data));
      end
    end
  end

  task automatic cyc(input bit pe, input bit vid, input bit hs, input bit vs,
                     input bit push, input logic [14:0] a, input logic [7:0] d, input int ack);
    @(negedge clk);
    drv_vclr     = vsyncIn && !vs;
    pixEn        = pe;
    vidIn        = vid;
    hsyncIn      = hs;
    vsyncIn      = vs;
    drv_push     = push;
    drv_ent.addr = a;
    drv_ent.data = d;
    if (ack >= 0)          wrAck = 1'(ack);
    else if (ack_mode == 2) wrAck = 1'($urandom_range(0, 1));
    else                   wrAck = 1'(ack_mode);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1, 1, 0, '0, '0, -1);
  endtask

  task automatic vsync_fall();
    cyc(1'($urandom_range(0, 1)), 0, 1, 0, 0, '0, '0, -1);
    idle(2);
    line_no = 0;
    armed   = 1'b1;
    repeat (V_SKIP) begin
      cyc(1'($urandom_range(0, 1)), 0, 0, 1, 0, '0, '0, -1);
      idle(2);
    end
  endtask

  // One line: hsync fall, skipped strobes, then npix pixels; ack forced high on the push of byte ack_byte.
  task automatic line(input int npix, input int ack_byte, input bit fixed, input logic [7:0] fbyte);
    logic [7:0] sh;
    bit v, pu;
    sh = '0;
    cyc(1'($urandom_range(0, 1)), 0, 0, 1, 0, '0, '0, -1);
    idle($urandom_range(0, 2));
    repeat (H_SKIP) begin
      cyc(1, 1'($urandom_range(0, 1)), 1, 1, 0, '0, '0, -1);
      idle($urandom_range(0, 1));
    end
    for (int p = 0; p < npix; p++) begin
      v  = fixed ? fbyte[7 - (p % 8)] : 1'($urandom_range(0, 1));
      sh = {sh[6:0], v ^ INV};
      pu = armed && (p % 8 == 7);
      cyc(1, v, 1, 1, pu, 15'(line_no * BPL + p / 8), sh, (pu && (p / 8 == ack_byte)) ? 1 : -1);
      if (p < npix - 1) idle($urandom_range(0, 2));
    end
    if (armed) begin
      line_no++;
      if (line_no == V_ACTIVE) armed = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0; pixEn = 1'b0; vidIn = 1'b0; hsyncIn = 1'b1; vsyncIn = 1'b1; wrAck = 1'b0;
    drv_push = 1'b0; drv_vclr = 1'b0; chk_en = 1'b0; armed = 1'b0; ack_mode = 0;
    vectors = 0; errors = 0; n_writes = 0; line_no = 0; last_addr = '0;
    exp_b = INV ? 8'h4E : 8'hB1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrReq", 32'(wrReq), 0);
    check("rst_wrAddr", 32'(wrAddr), 0);
    check("rst_wrData", 32'(wrData), 0);
    check("rst_capActive", 32'(capActive), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    nReset = 1'b1;
    chk_en = 1'b1;

    // Single known byte, arbiter always ready.
    ack_mode = 1;
    vsync_fall();
    line(8, -1, 1'b1, 8'hB1);
    idle(1); #1;
    check("t1_wrReq_hi", 32'(wrReq), 1);
    check("t1_wrData", 32'(wrData), 32'(exp_b));
    check("t1_wrAddr", 32'(wrAddr), 0);
    check("t1_capActive", 32'(capActive), 1);
    idle(1); #1;
    check("t1_wrReq_lo", 32'(wrReq), 0);
    check("t1_writes", 32'(n_writes), 1);
    vsync_fall(); #1;
    check("t1_cap_after_vs", 32'(capActive), 0);

    // Full frame with random acks.
    ack_mode = 2;
    base = n_writes;
    line(H_ACTIVE, -1, 1'b0, '0);
    idle(1); #1;
    check("t2_cap_hwait", 32'(capActive), 0);
    repeat (V_ACTIVE - 1) line(H_ACTIVE, -1, 1'b0, '0);
    ack_mode = 1;
    idle(8); #1;
    check("t2_writes", 32'(n_writes - base), V_ACTIVE * BPL);
    check("t2_last_addr", 32'(last_addr), V_ACTIVE * BPL - 1);
    check("t2_cap_idle", 32'(capActive), 0);
    base = n_writes;
    line(64, -1, 1'b0, '0);
    idle(4); #1;
    check("t2_idle_no_wr", 32'(n_writes - base), 0);

    // Overflow: five bytes into a four-entry FIFO with no acks.
    vsync_fall();
    ack_mode = 0;
    base = n_writes;
    line(40, -1, 1'b0, '0);
    idle(1); #1;
    check("t3_ovf_set", 32'(ovf), 1);
    check("t3_head_addr", 32'(wrAddr), 0);
    ack_mode = 1;
    idle(8); #1;
    check("t3_pops", 32'(n_writes - base), 4);
    for (int i = 0; i < 4; i++) check("t3_order", 32'(seen_addr[base + i]), i);
    check("t3_ovf_sticky", 32'(ovf), 1);
    vsync_fall(); #1;
    check("t3_ovf_clr", 32'(ovf), 0);

    // Full FIFO with ack on the push clk: nothing dropped.
    ack_mode = 0;
    base = n_writes;
    line(40, 4, 1'b0, '0);
    idle(1); #1;
    check("t4_ovf", 32'(ovf), 0);
    check("t4_head_addr", 32'(wrAddr), 1);
    ack_mode = 1;
    idle(8); #1;
    check("t4_writes", 32'(n_writes - base), 5);
    check("t4_last_addr", 32'(last_addr), 4);

    // Short line: 100 pixels then a new line.
    vsync_fall();
    ack_mode = 2;
    base = n_writes;
    line(100, -1, 1'b0, '0);
    ack_mode = 1;
    idle(6); #1;
    check("t5_short_writes", 32'(n_writes - base), 12);
    check("t5_short_last", 32'(last_addr), 11);
    base = n_writes;
    ack_mode = 2;
    line(16, -1, 1'b0, '0);
    ack_mode = 1;
    idle(6); #1;
    check("t5_next_writes", 32'(n_writes - base), 2);
    check("t5_next_addr", 32'(seen_addr[base]), BPL);

    // Asynchronous reset with entries queued.
    vsync_fall();
    ack_mode = 0;
    line(24, -1, 1'b0, '0);
    idle(1); #1;
    check("t6_queued", 32'(wrReq), 1);
    @(posedge clk);
    #2 nReset = 1'b0;
    #1;
    check("t6_rst_wrReq", 32'(wrReq), 0);
    check("t6_rst_wrAddr", 32'(wrAddr), 0);
    check("t6_rst_wrData", 32'(wrData), 0);
    check("t6_rst_cap", 32'(capActive), 0);
    @(negedge clk);
    nReset = 1'b1;
    armed = 1'b0;
    ack_mode = 2;
    base = n_writes;
    line(64, -1, 1'b0, '0);
    idle(5); #1;
    check("t6_no_wr", 32'(n_writes - base), 0);
    vsync_fall();
    line(16, -1, 1'b0, '0);
    ack_mode = 1;
    idle(6); #1;
    check("t6_recover", 32'(n_writes - base), 2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
